imem_boot_loader: RTL and testbench

- Fills the instruction memory from a byte stream, then releases the core to run.
- Receives a little-endian 16-bit word count, then 4*N bytes of program.
- Assembles each group of 4 bytes into a 32-bit instruction and writes it to consecutive word addresses starting at 0.
- Holds the core's PC/register path in reset until the whole image is written; asserts cpu_run afterwards.

---
 rtl/imem_boot_loader_if.sv | 22 ++
 rtl/imem_boot_loader.sv | 115 +++++++++++
 tb/tb_imem_boot_loader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - byte-stream input and instruction-memory write bus for the boot loader
interface imem_boot_loader_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - loads a length-prefixed little-endian image into imem, then releases the core
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WORDS  = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    imem_boot_loader_if.slave   bus,
    output logic                cpu_run,
    output logic                busy,
    output logic                error,
    output logic [15:0]         words_loaded
);
    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        DONE,
        ERROR
    } state_t;

    state_t                state, state_next;
    logic                  ready;
    logic                  accept;
    logic [15:0]           len_q;
    logic [15:0]           len_full;
    logic                  len_bad;
    logic                  last_word;
    logic [1:0]            byte_idx;
    logic [23:0]           shift_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    assign accept    = bus.in_valid && ready;
    assign len_full  = {bus.in_data, len_q[7:0]};
    assign len_bad   = (len_full == 16'd0) || ({16'd0, len_full} > MAX_WORDS);
    assign last_word = ((words_loaded + 16'd1) == len_q);

    assign bus.in_ready   = ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LEN_LO;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        case (state)
            LEN_LO: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (accept) state_next = LEN_HI;
            end
            LEN_HI: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (accept) state_next = len_bad ? ERROR : DATA;
            end
            DATA: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (accept && byte_idx == 2'd3 && last_word) state_next = DONE;
            end
            DONE:    state_next = DONE;
            ERROR:   state_next = ERROR;
            default: state_next = LEN_LO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q        <= '0;
            byte_idx     <= '0;
            shift_q      <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_run      <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            we_q <= 1'b0;
            // The final write lands the cycle before, so the core never fetches a stale word
            if (state == DONE) cpu_run <= 1'b1;
            if (state_next == ERROR) error <= 1'b1;
            if (accept) begin
                case (state)
                    LEN_LO: len_q[7:0] <= bus.in_data;
                    LEN_HI: begin
                        len_q[15:8] <= bus.in_data;
                        byte_idx    <= '0;
                    end
                    DATA: begin
                        shift_q  <= {bus.in_data, shift_q[23:8]};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            we_q         <= 1'b1;
                            wdata_q      <= DATA_WIDTH'({bus.in_data, shift_q});
                            addr_q       <= ADDR_WIDTH'({words_loaded, 2'b00});
                            words_loaded <= words_loaded + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed checks of the imem boot loader
module tb_imem_boot_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_run, busy, error;
    logic [15:0] words_loaded;

    imem_boot_loader_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

    imem_boot_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MAX_WORDS(1024)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .cpu_run      (cpu_run),
        .busy         (busy),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          we_cyc = -1;
    int          run_cyc = -1;
    logic        run_prev = 1'b0;
    logic [15:0] wr_addr[$];
    logic [31:0] wr_data[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.imem_we) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
            we_cyc = cyc;
        end
        if (cpu_run && !run_prev) run_cyc = cyc;
        run_prev = cpu_run;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        we_cyc   = -1;
        run_cyc  = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_we", 32'(bus.imem_we), 0);
        check("rst_addr", 32'(bus.imem_addr), 0);
        check("rst_wdata", bus.imem_wdata, 0);
        check("rst_run", 32'(cpu_run), 0);
        check("rst_err", 32'(error), 0);
        check("rst_words", 32'(words_loaded), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        clear_log();
        run_prev = 1'b0;
        check("rst_ready", 32'(bus.in_ready), 1);
        check("rst_busy", 32'(busy), 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) check("accept_timeout", 0, 1);
    endtask

    task automatic stop_stream();
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic junk(input int ncyc, output int ready_seen);
        ready_seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
            #1 if (bus.in_ready) ready_seen++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_basic(input int maxgap);
        logic [7:0] s[10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        for (int i = 0; i < 10; i++) send_byte(s[i], $urandom_range(0, maxgap));
        stop_stream();
    endtask

    task automatic check_basic(input string p);
        check({p, "_nwr"}, wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            check({p, "_a0"}, 32'(wr_addr[0]), 32'h0000);
            check({p, "_d0"}, wr_data[0], 32'h00100513);
            check({p, "_a1"}, 32'(wr_addr[1]), 32'h0004);
            check({p, "_d1"}, wr_data[1], 32'h00200593);
        end
        check({p, "_words"}, 32'(words_loaded), 2);
        check({p, "_run"}, 32'(cpu_run), 1);
        check({p, "_run_lat"}, 32'(run_cyc - we_cyc), 1);
        check({p, "_ready"}, 32'(bus.in_ready), 0);
        check({p, "_busy"}, 32'(busy), 0);
        check({p, "_err"}, 32'(error), 0);
    endtask

    task automatic bad_len(input string p, input logic [7:0] lo, input logic [7:0] hi);
        int rs;
        do_reset();
        send_byte(lo, 0);
        send_byte(hi, 0);
        stop_stream();
        check({p, "_err"}, 32'(error), 1);
        check({p, "_ready"}, 32'(bus.in_ready), 0);
        check({p, "_busy"}, 32'(busy), 0);
        junk(10, rs);
        check({p, "_junk_ready"}, 32'(rs), 0);
        check({p, "_nwr"}, wr_addr.size(), 0);
        check({p, "_run"}, 32'(cpu_run), 0);
        check({p, "_err_sticky"}, 32'(error), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rs;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        do_reset();
        send_basic(0);
        check_basic("basic");
        junk(20, rs);
        check("post_ready", 32'(rs), 0);
        check("post_nwr", wr_addr.size(), 2);
        check("post_run", 32'(cpu_run), 1);
        check("post_words", 32'(words_loaded), 2);
        check("post_addr_hold", 32'(bus.imem_addr), 32'h0004);
        check("post_data_hold", bus.imem_wdata, 32'h00200593);

        do_reset();
        send_basic(3);
        check_basic("gap");

        bad_len("len0", 8'h00, 8'h00);
        bad_len("len1025", 8'h01, 8'h04);

        do_reset();
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 1);
        send_byte(8'h33, 0);
        send_byte(8'h44, 2);
        send_byte(8'h55, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_nwr_before", wr_addr.size(), 1);
        check("mid_rst_we", 32'(bus.imem_we), 0);
        check("mid_rst_addr", 32'(bus.imem_addr), 0);
        check("mid_rst_wdata", bus.imem_wdata, 0);
        check("mid_rst_words", 32'(words_loaded), 0);
        check("mid_rst_run", 32'(cpu_run), 0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        clear_log();
        run_prev = 1'b0;
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hDE, 0);
        stop_stream();
        check("mid_nwr", wr_addr.size(), 1);
        if (wr_addr.size() == 1) begin
            check("mid_a0", 32'(wr_addr[0]), 0);
            check("mid_d0", wr_data[0], 32'hDEADBEEF);
        end
        check("mid_words", 32'(words_loaded), 1);
        check("mid_run", 32'(cpu_run), 1);

        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        for (int w = 0; w < 1024; w++) begin
            send_byte(8'(w), 0);
            send_byte(8'(w >> 8), 0);
            send_byte(8'h00, 0);
            send_byte(8'h00, 0);
            if (w == 1022) check("max_run_early", 32'(cpu_run), 0);
        end
        stop_stream();
        check("max_nwr", wr_addr.size(), 1024);
        if (wr_addr.size() == 1024) begin
            for (int w = 0; w < 1024; w++) begin
                check($sformatf("max_a%0d", w), 32'(wr_addr[w]), 32'(w * 4));
                check($sformatf("max_d%0d", w), wr_data[w], 32'(w));
            end
            check("max_last_a", 32'(wr_addr[1023]), 32'h0FFC);
            check("max_last_d", wr_data[1023], 32'h000003FF);
        end
        check("max_words", 32'(words_loaded), 1024);
        check("max_err", 32'(error), 0);
        check("max_run", 32'(cpu_run), 1);
        check("max_run_lat", 32'(run_cyc - we_cyc), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
